// File: rtl/booth_mac_accumulator.sv
// Signed saturating multiply-accumulate back end for Booth multiplier products.
// Accumulates a fixed-length job of products and hands the result off via valid/ready.
module booth_mac_accumulator #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic                    write_clock,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  input  logic                    prod_valid,
  input  logic signed [63:0]      product,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    busy,
  output logic                    overflow,
  output logic [CNT_W-1:0]        count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic [CNT_W-1:0]        len_q;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sat_sum;
  logic                    ovf_pos;
  logic                    ovf_neg;
  logic                    last;

  // Overflow only when both operands share a sign the wrapped sum lacks.
  always_comb begin
    prod_ext = ACC_W'(product);
    sum      = acc_out + prod_ext;
    ovf_pos  = !acc_out[ACC_W-1] && !prod_ext[ACC_W-1]
             && sum[ACC_W-1];
    ovf_neg  = acc_out[ACC_W-1] && prod_ext[ACC_W-1]
             && !sum[ACC_W-1];
    sat_sum  = sum;
    unique case (1'b1)
      ovf_pos: sat_sum = ACC_MAX;
      ovf_neg: sat_sum = ACC_MIN;
      default: sat_sum = sum;
    endcase
    last = (count == len_q - 1'b1);
  end

  always_ff @(posedge write_clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      len_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            len_q    <= len;
            busy     <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              acc_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_out <= sat_sum;
            count   <= count + 1'b1;
            if (ovf_pos || ovf_neg)
              overflow <= 1'b1;
            if (last) begin
              state     <= DONE;
              acc_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Scoreboard bench for booth_mac_accumulator (ACC_W=64).
// Jobs push expected results; a negedge monitor pops them on acc_valid.
module tb_booth_mac_accumulator;

  localparam int ACC_W = 64;
  localparam int CNT_W = 8;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic                    write_clock = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [CNT_W-1:0]        len = '0;
  logic                    prod_valid = 1'b0;
  logic signed [63:0]      product = '0;
  logic signed [ACC_W-1:0] acc_out;
  logic                    acc_valid;
  logic                    acc_ready = 1'b0;
  logic                    busy;
  logic                    overflow;
  logic [CNT_W-1:0]        count;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  logic seen = 1'b0;

  booth_mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .write_clock(write_clock),
    .rst(rst),
    .start(start),
    .len(len),
    .prod_valid(prod_valid),
    .product(product),
    .acc_out(acc_out),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .busy(busy),
    .overflow(overflow),
    .count(count)
  );

  always #5 write_clock = ~write_clock;

  task automatic chk(input string nm, input logic [ACC_W-1:0] act,
                     input logic [ACC_W-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  // Monitor: one pop per result presentation.
  always @(negedge write_clock) begin
    if (!rst && acc_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_acc", acc_out, e.acc);
        chk("sb_count", ACC_W'(count), ACC_W'(e.cnt));
        chk("sb_overflow", ACC_W'(overflow), ACC_W'(e.ovf));
      end
    end
    if (!acc_valid) seen = 1'b0;
  end

  task automatic tick();
    @(posedge write_clock);
    #1;
  endtask

  task automatic start_job(input int l, input logic [63:0] a,
                           input int c, input logic o);
    exp_t e;
    e.acc = a;
    e.cnt = CNT_W'(c);
    e.ovf = o;
    exp_q.push_back(e);
    start = 1'b1;
    len   = CNT_W'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] p);
    prod_valid = 1'b1;
    product    = p;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!acc_valid && k < 50) begin
      tick();
      k++;
    end
    if (!acc_valid) chk("wait_done_timeout", 0, 1);
    @(negedge write_clock);
    #1;
  endtask

  task automatic accept();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("accept_valid_low", ACC_W'(acc_valid), 0);
    chk("accept_busy_low", ACC_W'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_acc", acc_out, 0);
    chk("rst_valid", ACC_W'(acc_valid), 0);
    chk("rst_busy", ACC_W'(busy), 0);
    chk("rst_count", ACC_W'(count), 0);
    #12 rst = 1'b0;
    tick();

    // Basic job: 5 - 2 + 10 = 13, valid right after the third edge.
    start_job(3, 64'd13, 3, 1'b0);
    chk("busy_accum", ACC_W'(busy), 1);
    send(64'd5);
    send(-64'sd2);
    chk("no_early_valid", ACC_W'(acc_valid), 0);
    send(64'd10);
    chk("latency_valid", ACC_W'(acc_valid), 1);
    wait_done();
    accept();
    chk("idle_hold_acc", acc_out, 64'd13);

    // Products in IDLE are dropped.
    send(64'd100);
    send(64'd100);
    chk("idle_drop_acc", acc_out, 64'd13);
    chk("idle_drop_cnt", ACC_W'(count), 3);

    // Bubbles between products.
    start_job(2, 64'd0, 2, 1'b0);
    chk("start_clears_acc", acc_out, 0);
    send(64'd7);
    repeat (4) tick();
    chk("bubble_hold", acc_out, 64'd7);
    send(-64'sd7);
    wait_done();
    accept();

    // Positive saturation.
    start_job(2, 64'h7FFF_FFFF_FFFF_FFFF, 2, 1'b1);
    send(64'h7FFF_FFFF_FFFF_FFFF);
    send(64'd1);
    wait_done();
    accept();
    chk("ovf_readable_idle", ACC_W'(overflow), 1);

    // Negative saturation then continue from the clamp.
    start_job(3, 64'h8000_0000_0000_0005, 3, 1'b1);
    chk("start_clears_ovf", ACC_W'(overflow), 0);
    send(64'h8000_0000_0000_0000);
    send(-64'sd1);
    chk("neg_clamp", acc_out, 64'h8000_0000_0000_0000);
    send(64'd5);
    wait_done();
    accept();

    // Back-pressure with start and prod_valid ignored in DONE.
    start_job(1, 64'd42, 1, 1'b0);
    send(64'd42);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      start      = 1'b1;
      len        = 8'd5;
      prod_valid = 1'b1;
      product    = 64'd999;
      tick();
      chk("bp_acc", acc_out, 64'd42);
      chk("bp_valid", ACC_W'(acc_valid), 1);
      chk("bp_count", ACC_W'(count), 1);
    end
    start      = 1'b0;
    prod_valid = 1'b0;
    accept();

    // Zero-length job.
    start_job(0, 64'd0, 0, 1'b0);
    chk("zero_len_valid", ACC_W'(acc_valid), 1);
    wait_done();
    accept();

    // Mid-job reset abandons the job.
    start_job(5, 64'd0, 0, 1'b0);
    send(64'd11);
    send(64'd22);
    void'(exp_q.pop_back());
    rst = 1'b1;
    #1;
    chk("mrst_acc", acc_out, 0);
    chk("mrst_count", ACC_W'(count), 0);
    chk("mrst_busy", ACC_W'(busy), 0);
    chk("mrst_valid", ACC_W'(acc_valid), 0);
    #3 rst = 1'b0;
    tick();
    start_job(1, -64'sd9, 1, 1'b0);
    send(-64'sd9);
    wait_done();
    accept();

    tick();
    chk("queue_drained", ACC_W'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
